// File: rtl/mem_uart_pkg.sv
// Shared encodings for the mem_uart arbiter: FSM states, owner/op codes and the
// two-way round-robin pick.
package mem_uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   localparam logic OWN_A = 1'b0;
   localparam logic OWN_B = 1'b1;

   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;

   // pending[0] is A, pending[1] is B; on a tie the side that did not win last goes.
   function automatic logic rr_pick(input logic [1:0] pending, input logic last);
      if (pending == 2'b11) begin
         return ~last;
      end
      return pending[1] ? OWN_B : OWN_A;
   endfunction

endpackage

// File: rtl/mem_uart_arb.sv
// Round-robin arbiter sharing one mem_uart master port between requesters A and B;
// the winning request is latched and replayed until the master accepts it.
module mem_uart_arb
   import mem_uart_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 64
) (
   input  logic                  i_clk,
   input  logic                  i_nrst,
   input  logic [ADDR_WIDTH-1:0] i_a_addr,
   input  logic [DATA_WIDTH-1:0] i_a_data,
   output logic [DATA_WIDTH-1:0] o_a_data,
   input  logic                  i_a_read_valid,
   output logic                  o_a_read_accept,
   input  logic                  i_a_write_valid,
   output logic                  o_a_write_accept,
   input  logic [ADDR_WIDTH-1:0] i_b_addr,
   input  logic [DATA_WIDTH-1:0] i_b_data,
   output logic [DATA_WIDTH-1:0] o_b_data,
   input  logic                  i_b_read_valid,
   output logic                  o_b_read_accept,
   input  logic                  i_b_write_valid,
   output logic                  o_b_write_accept,
   output logic [ADDR_WIDTH-1:0] o_m_addr,
   output logic [DATA_WIDTH-1:0] o_m_data,
   input  logic [DATA_WIDTH-1:0] i_m_data,
   output logic                  o_m_read_valid,
   input  logic                  i_m_read_accept,
   output logic                  o_m_write_valid,
   input  logic                  i_m_write_accept,
   output logic                  o_busy,
   output logic                  o_owner
);

   state_t                  state_q;
   logic                    rr_last_q;
   logic                    owner_q;
   logic                    op_q;
   logic                    busy_q;
   logic [ADDR_WIDTH-1:0]   m_addr_q;
   logic [DATA_WIDTH-1:0]   m_data_q;
   logic                    m_rd_q, m_wr_q;
   logic [DATA_WIDTH-1:0]   a_data_q, b_data_q;
   logic                    a_racc_q, a_wacc_q, b_racc_q, b_wacc_q;

   logic [1:0]              pending;
   logic                    grant_d;
   logic                    grant_wr_d;
   logic [ADDR_WIDTH-1:0]   grant_addr_d;
   logic [DATA_WIDTH-1:0]   grant_data_d;
   logic                    m_done;

   // NOTE: every signal gets a value on every path through always_comb; otherwise a latch is inferred.
   always_comb begin
      pending      = {i_b_read_valid | i_b_write_valid, i_a_read_valid | i_a_write_valid};
      grant_d      = rr_pick(pending, rr_last_q);
      grant_wr_d   = (grant_d == OWN_B) ? i_b_write_valid : i_a_write_valid;
      grant_addr_d = (grant_d == OWN_B) ? i_b_addr : i_a_addr;
      grant_data_d = (grant_d == OWN_B) ? i_b_data : i_a_data;
      m_done       = (op_q == OP_WR) ? i_m_write_accept : i_m_read_accept;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q   <= ST_IDLE;
         rr_last_q <= OWN_B;
         owner_q   <= OWN_A;
         op_q      <= OP_RD;
         busy_q    <= 1'b0;
         m_addr_q  <= '0;
         m_data_q  <= '0;
         m_rd_q    <= 1'b0;
         m_wr_q    <= 1'b0;
         a_data_q  <= '0;
         b_data_q  <= '0;
         a_racc_q  <= 1'b0;
         a_wacc_q  <= 1'b0;
         b_racc_q  <= 1'b0;
         b_wacc_q  <= 1'b0;
      end else begin
         a_racc_q <= 1'b0;
         a_wacc_q <= 1'b0;
         b_racc_q <= 1'b0;
         b_wacc_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (|pending) begin
                  // Write wins when one requester raises both valids; its read stays pending.
                  op_q      <= grant_wr_d ? OP_WR : OP_RD;
                  m_wr_q    <= grant_wr_d;
                  m_rd_q    <= ~grant_wr_d;
                  m_addr_q  <= grant_addr_d;
                  m_data_q  <= grant_data_d;
                  owner_q   <= grant_d;
                  rr_last_q <= grant_d;
                  busy_q    <= 1'b1;
                  state_q   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (m_done) begin
                  m_rd_q   <= 1'b0;
                  m_wr_q   <= 1'b0;
                  a_racc_q <= (owner_q == OWN_A) && (op_q == OP_RD);
                  a_wacc_q <= (owner_q == OWN_A) && (op_q == OP_WR);
                  b_racc_q <= (owner_q == OWN_B) && (op_q == OP_RD);
                  b_wacc_q <= (owner_q == OWN_B) && (op_q == OP_WR);
                  if (op_q == OP_RD) begin
                     if (owner_q == OWN_B) b_data_q <= i_m_data;
                     else                  a_data_q <= i_m_data;
                  end
                  state_q <= ST_ACK;
               end
            end
            ST_ACK: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_a_data         = a_data_q;
   assign o_b_data         = b_data_q;
   assign o_a_read_accept  = a_racc_q;
   assign o_a_write_accept = a_wacc_q;
   assign o_b_read_accept  = b_racc_q;
   assign o_b_write_accept = b_wacc_q;
   assign o_m_addr         = m_addr_q;
   assign o_m_data         = m_data_q;
   assign o_m_read_valid   = m_rd_q;
   assign o_m_write_valid  = m_wr_q;
   assign o_busy           = busy_q;
   assign o_owner          = owner_q;

endmodule

// File: tb/tb_mem_uart_arb.sv
// Directed bench for mem_uart_arb: a per-cycle vector table for arbitration and
// stray-accept behaviour plus hand-written sequences for data paths and reset.
module tb_mem_uart_arb;

   localparam int DW = 16;
   localparam int AW = 64;

   logic          i_clk = 1'b0;
   logic          i_nrst;
   logic [AW-1:0] i_a_addr, i_b_addr;
   logic [DW-1:0] i_a_data, i_b_data, i_m_data;
   logic [DW-1:0] o_a_data, o_b_data, o_m_data;
   logic [AW-1:0] o_m_addr;
   logic          i_a_read_valid, i_a_write_valid, i_b_read_valid, i_b_write_valid;
   logic          o_a_read_accept, o_a_write_accept, o_b_read_accept, o_b_write_accept;
   logic          o_m_read_valid, o_m_write_valid, i_m_read_accept, i_m_write_accept;
   logic          o_busy, o_owner;

   int errors = 0;
   int checks = 0;

   mem_uart_arb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .i_clk(i_clk), .i_nrst(i_nrst),
      .i_a_addr(i_a_addr), .i_a_data(i_a_data), .o_a_data(o_a_data),
      .i_a_read_valid(i_a_read_valid), .o_a_read_accept(o_a_read_accept),
      .i_a_write_valid(i_a_write_valid), .o_a_write_accept(o_a_write_accept),
      .i_b_addr(i_b_addr), .i_b_data(i_b_data), .o_b_data(o_b_data),
      .i_b_read_valid(i_b_read_valid), .o_b_read_accept(o_b_read_accept),
      .i_b_write_valid(i_b_write_valid), .o_b_write_accept(o_b_write_accept),
      .o_m_addr(o_m_addr), .o_m_data(o_m_data), .i_m_data(i_m_data),
      .o_m_read_valid(o_m_read_valid), .i_m_read_accept(i_m_read_accept),
      .o_m_write_valid(o_m_write_valid), .i_m_write_accept(i_m_write_accept),
      .o_busy(o_busy), .o_owner(o_owner)
   );

   always #5 i_clk = ~i_clk;

   // in  = {a_rd, a_wr, b_rd, b_wr, m_racc, m_wacc}
   // exp = {m_rd, m_wr, busy, owner, a_racc, a_wacc, b_racc, b_wacc}
   typedef struct {
      logic [5:0] in;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] ctl();
      return {o_m_read_valid, o_m_write_valid, o_busy, o_owner,
              o_a_read_accept, o_a_write_accept, o_b_read_accept, o_b_write_accept};
   endfunction

   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_inputs();
      {i_a_read_valid, i_a_write_valid, i_b_read_valid, i_b_write_valid} = 4'b0;
      {i_m_read_accept, i_m_write_accept} = 2'b0;
      i_m_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      i_nrst = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      i_nrst = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{6'b010100, 8'b01100000};
      vecs[1]  = '{6'b010101, 8'b00100100};
      vecs[2]  = '{6'b010100, 8'b00000000};
      vecs[3]  = '{6'b010100, 8'b01110000};
      vecs[4]  = '{6'b010101, 8'b00110001};
      vecs[5]  = '{6'b010100, 8'b00010000};
      vecs[6]  = '{6'b010100, 8'b01100000};
      vecs[7]  = '{6'b010101, 8'b00100100};
      vecs[8]  = '{6'b010100, 8'b00000000};
      vecs[9]  = '{6'b010100, 8'b01110000};
      vecs[10] = '{6'b010101, 8'b00110001};
      vecs[11] = '{6'b000000, 8'b00010000};
      vecs[12] = '{6'b000000, 8'b00010000};
      vecs[13] = '{6'b010000, 8'b01100000};
      vecs[14] = '{6'b000010, 8'b01100000};
      vecs[15] = '{6'b000010, 8'b01100000};
      vecs[16] = '{6'b000001, 8'b00100100};
      vecs[17] = '{6'b000000, 8'b00000000};

      i_a_addr = '0; i_b_addr = '0; i_a_data = '0; i_b_data = '0;
      do_reset();
      check("reset_ctl", ctl(), 8'h00);
      check("reset_a_data", o_a_data, 16'h0000);
      check("reset_b_data", o_b_data, 16'h0000);
      check("reset_m_addr", o_m_addr, 64'h0);

      // A write, B idle
      i_a_addr = 64'h0123_4567_89AB_CDEF;
      i_a_data = 16'hABCD;
      i_a_write_valid = 1'b1;
      step();
      check("wr_a_ctl", ctl(), 8'b01100000);
      check("wr_a_addr", o_m_addr, 64'h0123_4567_89AB_CDEF);
      check("wr_a_data", o_m_data, 16'hABCD);
      i_a_addr = 64'h0;
      i_a_data = 16'h0;
      step();
      check("wr_a_hold_addr", o_m_addr, 64'h0123_4567_89AB_CDEF);
      check("wr_a_hold_ctl", ctl(), 8'b01100000);
      i_m_write_accept = 1'b1;
      step();
      check("wr_a_ack", ctl(), 8'b00100100);
      i_a_write_valid = 1'b0;
      i_m_write_accept = 1'b0;
      step();
      check("wr_a_done", ctl(), 8'b00000000);

      // B read with returned data
      i_b_addr = 64'h10;
      i_b_read_valid = 1'b1;
      step();
      check("rd_b_ctl", ctl(), 8'b10110000);
      check("rd_b_addr", o_m_addr, 64'h10);
      i_m_data = 16'h5A5A;
      i_m_read_accept = 1'b1;
      step();
      check("rd_b_ack", ctl(), 8'b00110010);
      check("rd_b_data", o_b_data, 16'h5A5A);
      check("rd_b_a_data", o_a_data, 16'h0000);
      i_b_read_valid = 1'b0;
      i_m_read_accept = 1'b0;
      i_m_data = 16'h0;
      step();
      check("rd_b_done", ctl(), 8'b00010000);
      check("rd_b_data_hold", o_b_data, 16'h5A5A);

      // Tie alternation and stray read accept during a write, cycle by cycle
      do_reset();
      for (int k = 0; k < 18; k++) begin
         {i_a_read_valid, i_a_write_valid, i_b_read_valid, i_b_write_valid,
          i_m_read_accept, i_m_write_accept} = vecs[k].in;
         step();
         check($sformatf("vec%0d", k), ctl(), vecs[k].exp);
      end
      idle_inputs();

      // A raises read and write together: write first, read on the next grant
      i_a_addr = 64'h20;
      i_a_read_valid = 1'b1;
      i_a_write_valid = 1'b1;
      step();
      check("rw_first_wr", ctl(), 8'b01100000);
      i_m_write_accept = 1'b1;
      step();
      check("rw_wr_ack", ctl(), 8'b00100100);
      i_a_write_valid = 1'b0;
      i_m_write_accept = 1'b0;
      step();
      check("rw_idle", ctl(), 8'b00000000);
      step();
      check("rw_then_rd", ctl(), 8'b10100000);
      i_m_data = 16'h1234;
      i_m_read_accept = 1'b1;
      step();
      check("rw_rd_ack", ctl(), 8'b00101000);
      check("rw_rd_data", o_a_data, 16'h1234);
      i_a_read_valid = 1'b0;
      i_m_read_accept = 1'b0;
      step();
      check("rw_done", ctl(), 8'b00000000);

      // Reset while B's write is in flight, then a tie goes to A
      i_b_write_valid = 1'b1;
      step();
      check("rst_pre", ctl(), 8'b01110000);
      i_nrst = 1'b0;
      #1;
      check("rst_mid_ctl", ctl(), 8'b00000000);
      check("rst_mid_a_data", o_a_data, 16'h0000);
      #1;
      i_nrst = 1'b1;
      i_a_write_valid = 1'b1;
      step();
      check("rst_tie_a", ctl(), 8'b01100000);

      idle_inputs();
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
